// File: rtl/psum_tile_accumulator.sv
// ----------------------------------------------------------------------------
// psum_tile_accumulator
//
// Adds the per-PE partial sums of each finished tile into a per-output-channel
// accumulator array. It processes one lane per cycle. On the last column tile
// of a group it emits the sign-binarized activation word for the next BNN
// layer.
//
// Optional feature macro: PSUM_ACC_SATURATE_EN
//   defined   -> additions clamp to the signed ACC_WIDTH range and set a
//                sticky sat_flag
//   undefined -> additions wrap modulo 2^ACC_WIDTH, sat_flag tied to 0
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-low reset
//   in_valid     tile result vector present
//   in_ready     block can capture a vector (high only in IDLE)
//   in_results   NUM_PES signed lanes, lane k at [k*PSUM_WIDTH +: PSUM_WIDTH]
//   in_oc_base   output channel of lane 0
//   in_first     first column tile: overwrite instead of accumulate
//   in_last      last column tile: emit binarized word
//   busy         accumulation in progress
//   bin_valid    one-cycle pulse, bin_word / bin_oc_base valid
//   bin_word     bit k = 1 iff acc[oc_base+k] >= 0
//   bin_oc_base  oc_base of the emitting vector
//   rd_addr      debug readback address
//   rd_data      registered acc[rd_addr], one cycle latency
//   sat_flag     sticky saturation indicator
//
// Requires NUM_PES >= 2, ACC_WIDTH >= PSUM_WIDTH, MAX_OUT_CH a power of two.
// ----------------------------------------------------------------------------
module psum_tile_accumulator #(
    parameter int unsigned NUM_PES    = 64,
    parameter int unsigned PSUM_WIDTH = 20,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned MAX_OUT_CH = 128,
    parameter int unsigned CH_W       = $clog2(MAX_OUT_CH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_PES*PSUM_WIDTH-1:0] in_results,
    input  logic [CH_W-1:0]               in_oc_base,
    input  logic                          in_first,
    input  logic                          in_last,
    output logic                          busy,
    output logic                          bin_valid,
    output logic [NUM_PES-1:0]            bin_word,
    output logic [CH_W-1:0]               bin_oc_base,
    input  logic [CH_W-1:0]               rd_addr,
    output logic [ACC_WIDTH-1:0]          rd_data,
    output logic                          sat_flag
);

    localparam int unsigned KW = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
    localparam int unsigned RW = NUM_PES * PSUM_WIDTH;
    localparam logic [KW-1:0] LastLane = KW'(NUM_PES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } state_e;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_e                r_state;
    state_e                w_state_next;

    logic [KW-1:0]         r_k;
    logic [RW-1:0]         r_results;
    logic [CH_W-1:0]       r_oc_base;
    logic                  r_first;
    logic                  r_last;
    logic [NUM_PES-1:0]    r_bin;

    logic                  r_bin_valid;
    logic [NUM_PES-1:0]    r_bin_word;
    logic [CH_W-1:0]       r_bin_oc_base;
    logic [ACC_WIDTH-1:0]  r_rd_data;

    // Accumulator storage is intentionally not reset; in_first seeds it.
    logic [ACC_WIDTH-1:0]  r_acc [MAX_OUT_CH];

    logic                  w_accept;
    logic                  w_last_lane;
    logic [CH_W-1:0]       w_addr;
    logic signed [PSUM_WIDTH-1:0] w_lane;
    logic signed [ACC_WIDTH-1:0]  w_lane_ext;
    logic signed [ACC_WIDTH-1:0]  w_old;
    logic [ACC_WIDTH-1:0]  w_new;
    logic                  w_bit;
    logic [NUM_PES-1:0]    w_bin_next;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StAccum;
            StAccum: if (r_k == LastLane) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (r_state)
            StIdle:  in_ready = 1'b1;
            StAccum: busy     = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_accept    = in_valid && in_ready;
    assign w_last_lane = (r_state == StAccum) && (r_k == LastLane);

    // ------------------------------------------------------------------------
    // Lane datapath. The latched result vector is shifted right one lane per
    // cycle, so the current lane is always in the low bits.
    // ------------------------------------------------------------------------
    assign w_lane     = r_results[PSUM_WIDTH-1:0];
    assign w_lane_ext = ACC_WIDTH'(w_lane);
    // Channel addresses wrap naturally in CH_W bits.
    assign w_addr     = r_oc_base + CH_W'(r_k);
    assign w_old      = r_first ? '0 : r_acc[w_addr];

`ifdef PSUM_ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] AccMin = ~AccMax;

    logic signed [ACC_WIDTH:0] w_sum;
    logic                      w_ovf;
    logic                      r_sat;

    // One guard bit: overflow iff the two top bits of the wide sum differ.
    assign w_sum = (ACC_WIDTH+1)'(w_old) + (ACC_WIDTH+1)'(w_lane_ext);
    assign w_ovf = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    always_comb begin
        w_new = w_sum[ACC_WIDTH-1:0];
        if (w_ovf) begin
            w_new = w_sum[ACC_WIDTH] ? AccMin : AccMax;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sat <= 1'b0;
        end else if ((r_state == StAccum) && w_ovf) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`else
    assign w_new    = w_old + w_lane_ext;
    assign sat_flag = 1'b0;
`endif

    assign w_bit      = ~w_new[ACC_WIDTH-1];
    // Bits enter at the top, so after NUM_PES shifts lane 0 sits in bit 0.
    assign w_bin_next = {w_bit, r_bin[NUM_PES-1:1]};

    // ------------------------------------------------------------------------
    // Accumulator write port. Writes are suppressed while reset is asserted so
    // an aborted vector stops at the reset edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset && (r_state == StAccum)) begin
            r_acc[w_addr] <= w_new;
        end
    end

    // Readback returns the pre-write value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_acc[rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Vector capture, lane counter and binarized output
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k           <= '0;
            r_results     <= '0;
            r_oc_base     <= '0;
            r_first       <= 1'b0;
            r_last        <= 1'b0;
            r_bin         <= '0;
            r_bin_valid   <= 1'b0;
            r_bin_word    <= '0;
            r_bin_oc_base <= '0;
        end else begin
            r_bin_valid <= 1'b0;
            if (w_accept) begin
                r_k       <= '0;
                r_results <= in_results;
                r_oc_base <= in_oc_base;
                r_first   <= in_first;
                r_last    <= in_last;
                r_bin     <= '0;
            end else if (r_state == StAccum) begin
                r_k       <= r_k + KW'(1);
                r_results <= r_results >> PSUM_WIDTH;
                r_bin     <= w_bin_next;
                if (w_last_lane && r_last) begin
                    r_bin_valid   <= 1'b1;
                    r_bin_word    <= w_bin_next;
                    r_bin_oc_base <= r_oc_base;
                end
            end
        end
    end

    assign bin_valid   = r_bin_valid;
    assign bin_word    = r_bin_word;
    assign bin_oc_base = r_bin_oc_base;
    assign rd_data     = r_rd_data;

endmodule
